boot_loader: RTL and testbench
==============================

# boot_loader

Boot controller that sits directly upstream of the processor top level. It holds the pipeline in reset and streams a program image from a valid/ready source into instruction memory, one word per cycle at ascending addresses. On the final word it releases the processor reset so fetch starts at address 0. The processor reset is produced synchronously; the block itself resets asynchronously.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; MAX_WORDS = 2**ADDR_WIDTH
- DATA_WIDTH, 32, instruction word width
- HOLD_CYCLES, 4, cycles spent in HOLD after reset release; legal range is 1 to 255

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- reset  input  1  asynchronous, active-low reset
- s_valid  input  1  source word valid
- s_ready  output  1  block accepts a word this cycle
- s_data  input  DATA_WIDTH  instruction word
- s_last  input  1  marks the final word of the image
- imem_we  output  1  instruction-memory write enable
- imem_addr  output  ADDR_WIDTH  write word address
- imem_wdata  output  DATA_WIDTH  write data
- proc_reset  output  1  active-high reset to the processor
- boot_done  output  1  image loaded; processor running
- boot_error  output  1  load aborted
- word_count  output  ADDR_WIDTH+1  number of words accepted

## Operation
- Reset values: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, proc_reset=1, boot_done=0, boot_error=0, word_count=0, state=HOLD, hold counter=0.
- The block uses one-hot-equivalent states. Each state drives the outputs below, and only the listed transitions exist.
  - HOLD: s_ready=0, proc_reset=1. Moves to LOAD after exactly HOLD_CYCLES cycles.
  - LOAD: s_ready=1, proc_reset=1.
    - Each cycle with s_valid&s_ready is an accepted beat. It is written at address word_count, and word_count is then incremented.
    - An accepted beat with s_last=1 moves the block to RELEASE.
    - If the accepted beat is number MAX_WORDS-1 and s_last=0, the word is still written and the block moves to ERROR (overflow).
  - RELEASE: s_ready=0, proc_reset=1 for exactly one cycle. This lets the last write land. Then the block moves to RUN.
  - RUN: proc_reset=0, boot_done=1, s_ready=0. It stays in RUN until reset. s_valid is ignored.
  - ERROR: proc_reset=1, boot_error=1, s_ready=0. It stays in ERROR until reset.
- s_ready depends only on state. It never depends combinationally on s_valid.
- word_count saturates at MAX_WORDS and never wraps. imem_addr is its low ADDR_WIDTH bits, registered.
- An asynchronous reset assertion in any state returns the block to the reset values immediately. A partially written image is left in memory and is simply overwritten by the next load.

## Timing
- If a beat is accepted at edge n, then in cycle n+1 imem_we=1 and imem_addr/imem_wdata hold that beat. The write takes 1 cycle of latency, and one write is possible per cycle.
- Back-to-back beats produce back-to-back write cycles at consecutive addresses.
- If the s_last beat is accepted at edge n:
  - edge n+1: write issues and the block enters RELEASE
  - edge n+2: RUN; proc_reset falls, boot_done rises
- After reset deassertion, the first possible accepting edge is edge HOLD_CYCLES+1.
- A source stall (s_valid=0) inserts bubbles: imem_we=0 and the state is unchanged.

## Configuration
- The feature is controlled by the macro BOOT_CHECKSUM_EN.
- When defined:
  - Adds the input csum_expected (DATA_WIDTH bits).
  - Adds a running sum of all accepted words, taken mod 2**DATA_WIDTH and cleared on reset.
  - On the s_last beat, the sum including that word is compared with csum_expected. A mismatch sends the block to ERROR instead of RELEASE. The last word is still written.
- When undefined: the port, the adder and the comparison are all absent, and s_last always goes to RELEASE.

## Structure
- Shared package boot_pkg holds:
  - the state encoding constants (HOLD, LOAD, RELEASE, RUN, ERROR)
  - the default widths
- One sub-module, boot_checksum, contains the accumulator and comparator. It is instantiated only under BOOT_CHECKSUM_EN.

## Test plan
- Reset, then a 3-word image 0x11,0x22,0x33 with last on the third word:
  - writes go to addresses 0,1,2 on consecutive cycles
  - proc_reset falls 2 edges after the last accept
  - boot_done=1, word_count=3
- HOLD_CYCLES=4 with s_valid held at 1 from reset release: s_ready stays 0 for 4 cycles and the first write goes to address 0.
- Source stalls alternate s_valid 1/0 over 4 words:
  - imem_we pulses are each 1 cycle with no gaps in addresses
  - the final state is RUN
- ADDR_WIDTH=2 with 4 words and no s_last:
  - address 3 is written
  - boot_error=1, proc_reset stays 1, word_count=4
- reset pulled low mid-load after 2 words, then reloaded with 1 word: all outputs return to reset values asynchronously, and the reload writes address 0.
- BOOT_CHECKSUM_EN with words 1,2,3:
  - csum_expected=6 gives boot_done=1
  - csum_expected=7 gives boot_error=1

Source files
------------

// File: rtl/boot_pkg.sv
`default_nettype none
//============================================================================
// Module   : boot_pkg
// Purpose  : Shared state encoding and default widths for the boot loader.
// Revision : 1.0
//============================================================================
package boot_pkg;

    localparam int c_default_addr_width  = 8;
    localparam int c_default_data_width  = 32;
    localparam int c_default_hold_cycles = 4;

    localparam int c_state_width = 5;

    localparam logic [c_state_width-1:0] c_st_hold    = 5'b00001;
    localparam logic [c_state_width-1:0] c_st_load    = 5'b00010;
    localparam logic [c_state_width-1:0] c_st_release = 5'b00100;
    localparam logic [c_state_width-1:0] c_st_run     = 5'b01000;
    localparam logic [c_state_width-1:0] c_st_error   = 5'b10000;

    typedef enum logic [c_state_width-1:0] {
        HOLD    = c_st_hold,
        LOAD    = c_st_load,
        RELEASE = c_st_release,
        RUN     = c_st_run,
        ERROR   = c_st_error
    } boot_state_e;

endpackage
`default_nettype wire

// File: rtl/boot_loader_if.sv
`default_nettype none
//============================================================================
// Module   : boot_loader_if
// Purpose  : Image source stream plus instruction-memory write port.
// Revision : 1.0
//============================================================================
interface boot_loader_if #(
    parameter int ADDR_WIDTH = boot_pkg::c_default_addr_width,
    parameter int DATA_WIDTH = boot_pkg::c_default_data_width
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;

    // Master is the image source / memory observer, slave is the loader.
    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, imem_we, imem_addr, imem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/boot_checksum.sv
`default_nettype none
//============================================================================
// Module   : boot_checksum
// Purpose  : Running image sum and final-word compare (BOOT_CHECKSUM_EN).
// Revision : 1.0
//============================================================================
module boot_checksum
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  i_beat,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    input  wire logic [DATA_WIDTH-1:0] i_expected,
    output logic                       o_match
);

    logic [DATA_WIDTH-1:0] r_sum;
    logic [DATA_WIDTH-1:0] w_sum_next;

    // The compare must include the beat currently being accepted.
    assign w_sum_next = r_sum + i_data;
    assign o_match    = (w_sum_next == i_expected);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (i_beat) begin
            r_sum <= w_sum_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
//============================================================================
// Module   : boot_loader
// Purpose  : Holds the processor in reset while streaming an image into
//            instruction memory; optional checksum via BOOT_CHECKSUM_EN.
// Revision : 1.0
//============================================================================
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_WIDTH  = c_default_addr_width,
    parameter int DATA_WIDTH  = c_default_data_width,
    parameter int HOLD_CYCLES = c_default_hold_cycles
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    boot_loader_if.slave               bus,
`ifdef BOOT_CHECKSUM_EN
    input  wire logic [DATA_WIDTH-1:0] csum_expected,
`endif
    output logic                       proc_reset,
    output logic                       boot_done,
    output logic                       boot_error,
    output logic [ADDR_WIDTH:0]        word_count
);

    localparam logic [ADDR_WIDTH:0] c_max_words  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_last_index = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [7:0]          c_hold_last  = 8'(HOLD_CYCLES - 1);

    boot_state_e           r_state;
    logic [7:0]            r_hold_cnt;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic                  r_s_ready;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [DATA_WIDTH-1:0] r_imem_wdata;
    logic                  r_proc_reset;
    logic                  r_boot_done;
    logic                  r_boot_error;

    logic                  w_accept;
    logic                  w_csum_ok;

    assign w_accept = bus.s_valid & r_s_ready;

`ifdef BOOT_CHECKSUM_EN
    boot_checksum #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checksum (
        .clk        (clk),
        .reset      (reset),
        .i_beat     (w_accept),
        .i_data     (bus.s_data),
        .i_expected (csum_expected),
        .o_match    (w_csum_ok)
    );
`else
    assign w_csum_ok = 1'b1;
`endif

    // s_ready is updated together with the state so it never lingers into
    // RELEASE/ERROR; status outputs trail the state by one cycle, which keeps
    // the processor in reset until the last write has landed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= HOLD;
            r_hold_cnt   <= '0;
            r_word_count <= '0;
            r_s_ready    <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_proc_reset <= 1'b1;
            r_boot_done  <= 1'b0;
            r_boot_error <= 1'b0;
        end else begin
            r_imem_we    <= 1'b0;
            r_proc_reset <= (r_state != RUN);
            r_boot_done  <= (r_state == RUN);
            r_boot_error <= (r_state == ERROR);

            case (r_state)
                HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_state   <= LOAD;
                        r_s_ready <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end

                LOAD: begin
                    if (w_accept) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_count[ADDR_WIDTH-1:0];
                        r_imem_wdata <= bus.s_data;
                        if (r_word_count != c_max_words) begin
                            r_word_count <= r_word_count + 1'b1;
                        end
                        if (bus.s_last) begin
                            r_s_ready <= 1'b0;
                            r_state   <= w_csum_ok ? RELEASE : ERROR;
                        end else if (r_word_count == c_last_index) begin
                            r_s_ready <= 1'b0;
                            r_state   <= ERROR;
                        end
                    end
                end

                RELEASE: begin
                    r_state <= RUN;
                end

                RUN, ERROR: begin
                    r_s_ready <= 1'b0;
                end

                default: begin
                    r_s_ready <= 1'b0;
                    r_state   <= ERROR;
                end
            endcase
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign proc_reset     = r_proc_reset;
    assign boot_done      = r_boot_done;
    assign boot_error     = r_boot_error;
    assign word_count     = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
//============================================================================
// Module   : tb_boot_loader
// Purpose  : Self-checking bench for boot_loader (optionally BOOT_CHECKSUM_EN).
// Revision : 1.0
//============================================================================
module tb_boot_loader;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int HOLD = 4;
    localparam int MAXW = 256;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    boot_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          proc_reset;
    logic          boot_done;
    logic          boot_error;
    logic [AW:0]   word_count;
`ifdef BOOT_CHECKSUM_EN
    logic [DW-1:0] csum_expected = '0;
`endif

    boot_loader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
`ifdef BOOT_CHECKSUM_EN
        .csum_expected (csum_expected),
`endif
        .proc_reset    (proc_reset),
        .boot_done     (boot_done),
        .boot_error    (boot_error),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Timeline model: k = edges since reset release; the image's fate is
    // decided at end_edge and everything else follows from fixed offsets.
    int            k, nacc, end_edge;
    bit            ended, end_ok, last_acc;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data, msum;

    logic [DW-1:0] img[$];
    int            wlog[$];
    int            first_we_edge = -1;
    int            fall_edge     = -1;
    int            we_run        = 0;
    int            max_we_run    = 0;

    function automatic bit ready_at(int j);
        return (j >= HOLD) && !(ended && j >= end_edge);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                k = 0; nacc = 0; end_edge = 0;
                ended = 1'b0; end_ok = 1'b0; last_acc = 1'b0; msum = '0;
            end else begin
                k++;
                last_acc = bus.s_valid && ready_at(k - 1);
                if (last_acc) begin
                    last_addr = nacc[AW-1:0];
                    last_data = bus.s_data;
                    msum      = msum + bus.s_data;
                    nacc++;
                    if (bus.s_last) begin
                        ended    = 1'b1;
                        end_edge = k;
`ifdef BOOT_CHECKSUM_EN
                        end_ok   = (msum == csum_expected);
`else
                        end_ok   = 1'b1;
`endif
                    end else if (nacc == MAXW) begin
                        ended    = 1'b1;
                        end_edge = k;
                        end_ok   = 1'b0;
                    end
                end
            end
            #1;
            check("s_ready", bus.s_ready, ready_at(k));
            check("imem_we", bus.imem_we, last_acc);
            if (last_acc) begin
                check("imem_addr", bus.imem_addr, last_addr);
                check("imem_wdata", bus.imem_wdata, last_data);
            end
            check("word_count", word_count, nacc);
            check("proc_reset", proc_reset, !(ended && end_ok && k >= end_edge + 2));
            check("boot_done", boot_done, ended && end_ok && k >= end_edge + 2);
            check("boot_error", boot_error, ended && !end_ok && k >= end_edge + 1);
            if (reset) begin
                if (bus.imem_we) begin
                    wlog.push_back(int'(bus.imem_addr));
                    we_run++;
                    if (first_we_edge < 0) first_we_edge = k;
                end else begin
                    we_run = 0;
                end
                if (we_run > max_we_run) max_we_run = we_run;
                if (!proc_reset && fall_edge < 0) fall_edge = k;
            end
        end
    end

    task automatic clear_logs();
        wlog.delete();
        first_we_edge = -1;
        fall_edge     = -1;
        we_run        = 0;
        max_we_run    = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_good_csum();
`ifdef BOOT_CHECKSUM_EN
        logic [DW-1:0] s;
        s = '0;
        foreach (img[i]) s = s + img[i];
        csum_expected = s;
`endif
    endtask

    // mode 0: always valid, 1: alternate valid/idle, 2: random valid
    task automatic send_words(input int n, input bit with_last, input int mode);
        int idx = 0;
        int cyc = 0;
        bit v;
        while (idx < n && cyc < 3000) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.s_valid = v;
            bus.s_data  = img[idx];
            bus.s_last  = with_last && (idx == n - 1);
            if (v && bus.s_ready) idx++;
            cyc++;
        end
        if (idx < n) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: accepted=%0d required=%0d", idx, n);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // 3-word image, valid held high from reset release
        img = '{32'h11, 32'h22, 32'h33};
        set_good_csum();
        bus.s_valid = 1'b1;
        bus.s_data  = img[0];
        send_words(3, 1'b1, 0);
        repeat (4) @(negedge clk);
        check("t1_nwrites", wlog.size(), 3);
        foreach (wlog[i]) check("t1_addr", wlog[i], i);
        check("t1_first_we_edge", first_we_edge, 5);
        check("t1_fall_edge", fall_edge, 9);
        check("t1_word_count", word_count, 3);
        check("t1_boot_done", boot_done, 1);
        bus.s_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.s_valid = 1'b0;
        check("t1_run_ignores", wlog.size(), 3);

        // alternating stalls over 4 words
        apply_reset();
        img = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
        set_good_csum();
        send_words(4, 1'b1, 1);
        repeat (4) @(negedge clk);
        check("t2_nwrites", wlog.size(), 4);
        foreach (wlog[i]) check("t2_addr", wlog[i], i);
        check("t2_pulse_len", max_we_run, 1);
        check("t2_boot_done", boot_done, 1);

        // overflow: full memory without s_last
        apply_reset();
        img.delete();
        for (int i = 0; i < MAXW; i++) img.push_back($urandom);
        send_words(MAXW, 1'b0, 0);
        bus.s_valid = 1'b1;
        bus.s_last  = 1'b1;
        repeat (5) @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        check("t3_word_count", word_count, 256);
        check("t3_boot_error", boot_error, 1);
        check("t3_proc_reset", proc_reset, 1);
        check("t3_nwrites", wlog.size(), 256);
        check("t3_top_addr", wlog[255], 255);

        // asynchronous reset mid-load, then reload a single word
        apply_reset();
        img = '{32'h5, 32'h6, 32'h7};
        send_words(2, 1'b0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("t4_s_ready", bus.s_ready, 0);
        check("t4_imem_we", bus.imem_we, 0);
        check("t4_imem_addr", bus.imem_addr, 0);
        check("t4_imem_wdata", bus.imem_wdata, 0);
        check("t4_proc_reset", proc_reset, 1);
        check("t4_boot_done", boot_done, 0);
        check("t4_boot_error", boot_error, 0);
        check("t4_word_count", word_count, 0);
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        img = '{32'hCAFE0001};
        set_good_csum();
        send_words(1, 1'b1, 0);
        repeat (4) @(negedge clk);
        check("t4_nwrites", wlog.size(), 1);
        check("t4_reload_addr", wlog[0], 0);
        check("t4_done", boot_done, 1);

`ifdef BOOT_CHECKSUM_EN
        apply_reset();
        img = '{32'd1, 32'd2, 32'd3};
        csum_expected = 32'd6;
        send_words(3, 1'b1, 0);
        repeat (4) @(negedge clk);
        check("t5_csum_ok_done", boot_done, 1);
        check("t5_csum_ok_err", boot_error, 0);

        apply_reset();
        csum_expected = 32'd7;
        send_words(3, 1'b1, 0);
        repeat (4) @(negedge clk);
        check("t5_csum_bad_err", boot_error, 1);
        check("t5_csum_bad_done", boot_done, 0);
        check("t5_csum_bad_writes", wlog.size(), 3);
`endif

        // random images with random stalls
        for (int r = 0; r < 8; r++) begin
            apply_reset();
            n = $urandom_range(1, 24);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            set_good_csum();
`ifdef BOOT_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) csum_expected = csum_expected + 32'd1;
`endif
            send_words(n, 1'b1, 2);
            repeat (5) @(negedge clk);
            check("rnd_nwrites", wlog.size(), n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
